// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared TLB sizes and entry record types
//
// Purpose: entry count, index width and field widths used by the TLB and
// its lookup sub-module, plus the packed page/entry records they share.
package tlb_pkg;

  localparam int TLBNUM = 16;
  localparam int IDX_W  = $clog2(TLBNUM);
  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;
  localparam int C_W    = 3;

  // One page half of an entry (even or odd page).
  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
  } page_t;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    page_t             p0;
    page_t             p1;
  } entry_t;

endpackage

// File: rtl/tlb_match.sv
// rtl/tlb_match.sv - fully associative lookup over all TLB entries
//
// Purpose: compares one lookup key against every entry and returns the
// lowest-numbered hit with the selected page half; all zeros on a miss.
// Ports:
//   vpn2, odd_page, asid : lookup key (VA[31:13], VA[12], ASID)
//   present              : per-entry written-and-not-reset flags
//   entries              : flattened entry storage
//   found, index, page   : hit flag, hit entry number, selected page fields
module tlb_match
  import tlb_pkg::*;
(
  input  logic [VPN2_W-1:0]          vpn2,
  input  logic                       odd_page,
  input  logic [ASID_W-1:0]          asid,
  input  logic [TLBNUM-1:0]          present,
  input  entry_t [TLBNUM-1:0]        entries,
  output logic                       found,
  output logic [IDX_W-1:0]           index,
  output page_t                      page
);

  logic [TLBNUM-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      match[i] = present[i] && (entries[i].vpn2 == vpn2) &&
                 (entries[i].g || (entries[i].asid == asid));
    end
  end

  // Scan from the top down so the lowest-numbered match is the last
  // assignment and wins when software has left duplicate keys.
  always_comb begin
    found = |match;
    index = '0;
    page  = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (match[i]) begin
        index = IDX_W'(i);
        page  = odd_page ? entries[i].p1 : entries[i].p0;
      end
    end
  end

endmodule

// File: rtl/tlb.sv
// rtl/tlb.sv - 16-entry MIPS32 joint TLB with two lookup ports
//
// Purpose: holds TLBWI-written entries, returns contents for TLBR and
// serves instruction-fetch (s0) and data/TLBP (s1) lookups combinationally.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   s0_* / s1_*            : lookup keys in, found/index/page fields out
//   we, w_index, w_*       : TLBWI write strobe, target entry, entry fields
//   r_index, r_*           : TLBR entry select and entry contents
module tlb
  import tlb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  // fetch lookup
  input  logic [VPN2_W-1:0] s0_vpn2,
  input  logic              s0_odd_page,
  input  logic [ASID_W-1:0] s0_asid,
  output logic              s0_found,
  output logic [IDX_W-1:0]  s0_index,
  output logic [PFN_W-1:0]  s0_pfn,
  output logic [C_W-1:0]    s0_c,
  output logic              s0_d,
  output logic              s0_v,
  // data / TLBP lookup
  input  logic [VPN2_W-1:0] s1_vpn2,
  input  logic              s1_odd_page,
  input  logic [ASID_W-1:0] s1_asid,
  output logic              s1_found,
  output logic [IDX_W-1:0]  s1_index,
  output logic [PFN_W-1:0]  s1_pfn,
  output logic [C_W-1:0]    s1_c,
  output logic              s1_d,
  output logic              s1_v,
  // TLBWI
  input  logic              we,
  input  logic [IDX_W-1:0]  w_index,
  input  logic [VPN2_W-1:0] w_vpn2,
  input  logic [ASID_W-1:0] w_asid,
  input  logic              w_g,
  input  logic [PFN_W-1:0]  w_pfn0,
  input  logic [C_W-1:0]    w_c0,
  input  logic              w_d0,
  input  logic              w_v0,
  input  logic [PFN_W-1:0]  w_pfn1,
  input  logic [C_W-1:0]    w_c1,
  input  logic              w_d1,
  input  logic              w_v1,
  // TLBR
  input  logic [IDX_W-1:0]  r_index,
  output logic [VPN2_W-1:0] r_vpn2,
  output logic [ASID_W-1:0] r_asid,
  output logic              r_g,
  output logic [PFN_W-1:0]  r_pfn0,
  output logic [C_W-1:0]    r_c0,
  output logic              r_d0,
  output logic              r_v0,
  output logic [PFN_W-1:0]  r_pfn1,
  output logic [C_W-1:0]    r_c1,
  output logic              r_d1,
  output logic              r_v1
);

  entry_t [TLBNUM-1:0] entries;
  logic   [TLBNUM-1:0] present;
  entry_t              w_entry;
  entry_t              r_entry;
  page_t               s0_page;
  page_t               s1_page;

  assign w_entry = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                     p0: '{pfn: w_pfn0, c: w_c0, d: w_d0, v: w_v0},
                     p1: '{pfn: w_pfn1, c: w_c1, d: w_d1, v: w_v1}};

  // Only the present bits are reset; stale field contents are hidden
  // behind them, so the wide storage needs no reset network.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      present <= '0;
    end else if (we) begin
      present[w_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !reset) begin
      entries[w_index] <= w_entry;
    end
  end

  tlb_match u_match0 (
    .vpn2     (s0_vpn2),
    .odd_page (s0_odd_page),
    .asid     (s0_asid),
    .present  (present),
    .entries  (entries),
    .found    (s0_found),
    .index    (s0_index),
    .page     (s0_page)
  );

  tlb_match u_match1 (
    .vpn2     (s1_vpn2),
    .odd_page (s1_odd_page),
    .asid     (s1_asid),
    .present  (present),
    .entries  (entries),
    .found    (s1_found),
    .index    (s1_index),
    .page     (s1_page)
  );

  assign {s0_pfn, s0_c, s0_d, s0_v} = s0_page;
  assign {s1_pfn, s1_c, s1_d, s1_v} = s1_page;

  assign r_entry = present[r_index] ? entries[r_index] : '0;

  assign r_vpn2 = r_entry.vpn2;
  assign r_asid = r_entry.asid;
  assign r_g    = r_entry.g;
  assign {r_pfn0, r_c0, r_d0, r_v0} = r_entry.p0;
  assign {r_pfn1, r_c1, r_d1, r_v1} = r_entry.p1;

endmodule

// File: tb/tb_tlb.sv
// tb/tb_tlb.sv - self-checking bench for tlb with directed and random steps
module tb_tlb;

  logic        clk;
  logic        reset;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic        s0_odd_page, s1_odd_page;
  logic [7:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic        s0_d, s1_d, s0_v, s1_v;
  logic        we;
  logic [3:0]  w_index;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic        w_g;
  logic [19:0] w_pfn0, w_pfn1;
  logic [2:0]  w_c0, w_c1;
  logic        w_d0, w_v0, w_d1, w_v1;
  logic [3:0]  r_index;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic        r_d0, r_v0, r_d1, r_v1;

  int checks = 0;
  int failures = 0;

  tlb dut (
    .clk(clk), .reset(reset),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one record per entry, plus a written flag.
  typedef struct {
    bit        written;
    bit [18:0] vpn2;
    bit [7:0]  asid;
    bit        g;
    bit [19:0] pfn[2];
    bit [2:0]  c[2];
    bit        d[2];
    bit        v[2];
  } m_entry_t;

  m_entry_t model[16];

  // {found, index, pfn, c, d, v}
  function automatic logic [29:0] model_lookup(bit [18:0] vpn2, bit odd, bit [7:0] asid);
    for (int i = 0; i < 16; i++) begin
      if (model[i].written && model[i].vpn2 == vpn2 && (model[i].g || model[i].asid == asid))
        return {1'b1, 4'(i), model[i].pfn[odd], model[i].c[odd], model[i].d[odd], model[i].v[odd]};
    end
    return '0;
  endfunction

  function automatic logic [94:0] model_read(int idx);
    if (!model[idx].written) return '0;
    return {model[idx].vpn2, model[idx].asid, model[idx].g,
            model[idx].pfn[0], model[idx].c[0], model[idx].d[0], model[idx].v[0],
            model[idx].pfn[1], model[idx].c[1], model[idx].d[1], model[idx].v[1]};
  endfunction

  task automatic check(string tag, logic [94:0] obs, logic [94:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(int idx, bit [18:0] vpn2, bit [7:0] asid, bit g,
                       bit [19:0] pfn0, bit [2:0] c0, bit d0, bit v0,
                       bit [19:0] pfn1, bit [2:0] c1, bit d1, bit v1);
    we = 1'b1; w_index = 4'(idx); w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
  endtask

  task automatic commit_model();
    int i;
    i = int'(w_index);
    model[i].written = 1'b1;
    model[i].vpn2 = w_vpn2; model[i].asid = w_asid; model[i].g = w_g;
    model[i].pfn[0] = w_pfn0; model[i].c[0] = w_c0; model[i].d[0] = w_d0; model[i].v[0] = w_v0;
    model[i].pfn[1] = w_pfn1; model[i].c[1] = w_c1; model[i].d[1] = w_d1; model[i].v[1] = w_v1;
  endtask

  task automatic do_write(int idx, bit [18:0] vpn2, bit [7:0] asid, bit g,
                          bit [19:0] pfn0, bit [2:0] c0, bit d0, bit v0,
                          bit [19:0] pfn1, bit [2:0] c1, bit d1, bit v1);
    set_w(idx, vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1);
    tick();
    commit_model();
    we = 1'b0;
  endtask

  task automatic drive_s0(bit [18:0] vpn2, bit odd, bit [7:0] asid);
    s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid;
  endtask

  task automatic drive_s1(bit [18:0] vpn2, bit odd, bit [7:0] asid);
    s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid;
  endtask

  task automatic check_model(string tag);
    #1;
    check({tag, "_s0"}, 95'({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}),
          95'(model_lookup(s0_vpn2, s0_odd_page, s0_asid)));
    check({tag, "_s1"}, 95'({s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}),
          95'(model_lookup(s1_vpn2, s1_odd_page, s1_asid)));
    check({tag, "_r"}, {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
                        r_pfn1, r_c1, r_d1, r_v1}, model_read(int'(r_index)));
  endtask

  logic [18:0] pool_vpn2[4];
  logic [7:0]  pool_asid[3];

  initial begin
    for (int i = 0; i < 16; i++) model[i].written = 1'b0;
    reset = 1'b1; we = 1'b0;
    set_w(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    we = 1'b0;
    drive_s0(0, 0, 0); drive_s1(0, 0, 0); r_index = 4'd5;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_s0_found", 95'(s0_found), 95'(0));
    check("rst_s1_found", 95'(s1_found), 95'(0));
    check("rst_read5", {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
                        r_pfn1, r_c1, r_d1, r_v1}, 95'(0));

    // Entry 3, ASID-qualified
    do_write(3, 19'h00400, 8'h12, 0, 20'h01000, 3'd0, 0, 1, 20'h01001, 3'd0, 1, 1);
    drive_s0(19'h00400, 1, 8'h12);
    drive_s1(19'h00400, 1, 8'h13);
    r_index = 4'd3;
    #1;
    check("e3_found", 95'(s0_found), 95'(1));
    check("e3_index", 95'(s0_index), 95'(3));
    check("e3_pfn", 95'(s0_pfn), 95'(20'h01001));
    check("e3_d", 95'(s0_d), 95'(1));
    check("e3_asid_miss", 95'(s1_found), 95'(0));
    check("e3_miss_zero", 95'({s1_index, s1_pfn, s1_c, s1_d, s1_v}), 95'(0));
    check("e3_read_vpn2", 95'(r_vpn2), 95'(19'h00400));
    check_model("e3");

    // Entry 7, global, both ports with different page halves
    do_write(7, 19'h7FFFF, 8'h55, 1, 20'hAAAA0, 3'd2, 0, 1, 20'hBBBB1, 3'd3, 1, 0);
    drive_s0(19'h7FFFF, 0, 8'h00);
    drive_s1(19'h7FFFF, 1, 8'hFF);
    #1;
    check("g7_s0", 95'({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}),
          95'({1'b1, 4'd7, 20'hAAAA0, 3'd2, 1'b0, 1'b1}));
    check("g7_s1", 95'({s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}),
          95'({1'b1, 4'd7, 20'hBBBB1, 3'd3, 1'b1, 1'b0}));
    check_model("g7");

    // Duplicate key: lowest index wins, overwrite exposes the other
    do_write(9, 19'h12345, 8'h21, 0, 20'h00009, 3'd1, 0, 1, 20'h00019, 3'd1, 0, 1);
    do_write(2, 19'h12345, 8'h21, 0, 20'h00002, 3'd1, 0, 1, 20'h00012, 3'd1, 0, 1);
    drive_s0(19'h12345, 0, 8'h21);
    drive_s1(19'h12345, 1, 8'h21);
    #1;
    check("dup_idx2", 95'(s0_index), 95'(2));
    check("dup_pfn2", 95'(s1_pfn), 95'(20'h00012));
    set_w(2, 19'h1, 8'h21, 0, 20'h0000F, 3'd1, 0, 1, 20'h0001F, 3'd1, 0, 1);
    tick();
    commit_model();
    // Consecutive write in the very next cycle
    set_w(10, 19'h00ABC, 8'h44, 0, 20'h0000A, 3'd0, 1, 1, 20'h0001A, 3'd0, 0, 1);
    #1;
    check("dup_idx9", 95'(s0_index), 95'(9));
    tick();
    commit_model();
    we = 1'b0;
    drive_s0(19'h00ABC, 0, 8'h44);
    r_index = 4'd2;
    #1;
    check("b2b_found10", 95'({s0_found, s0_index}), 95'({1'b1, 4'd10}));
    check("ovw_read2", 95'(r_vpn2), 95'(19'h1));
    check_model("b2b");

    // Same-cycle write and lookup of entry 4
    drive_s0(19'h0C0DE, 0, 8'h77);
    r_index = 4'd4;
    set_w(4, 19'h0C0DE, 8'h77, 0, 20'h00444, 3'd5, 1, 1, 20'h00445, 3'd5, 1, 1);
    #1;
    check("sc_old_found", 95'(s0_found), 95'(0));
    check("sc_old_read", 95'(r_vpn2), 95'(0));
    tick();
    commit_model();
    we = 1'b0;
    #1;
    check("sc_new_found", 95'({s0_found, s0_index, s0_pfn}), 95'({1'b1, 4'd4, 20'h00444}));
    check_model("sc");

    // Mid-cycle reset pulse
    drive_s1(19'h7FFFF, 0, 8'h01);
    #1;
    reset = 1'b1;
    #1;
    check("ar_s0_found", 95'(s0_found), 95'(0));
    check("ar_s1_found", 95'(s1_found), 95'(0));
    check("ar_read4", {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
                       r_pfn1, r_c1, r_d1, r_v1}, 95'(0));
    for (int i = 0; i < 16; i++) model[i].written = 1'b0;
    // Write coinciding with reset is ignored
    set_w(6, 19'h06666, 8'h66, 1, 20'h00666, 3'd0, 0, 1, 20'h00667, 3'd0, 0, 1);
    tick();
    we = 1'b0;
    reset = 1'b0;
    drive_s0(19'h06666, 0, 8'h66);
    r_index = 4'd6;
    #1;
    check("rst_we_ignored", 95'(s0_found), 95'(0));
    check_model("post_rst");

    // Randomized writes and lookups against the model
    pool_vpn2[0] = 19'h00010; pool_vpn2[1] = 19'h00020;
    pool_vpn2[2] = 19'h40000; pool_vpn2[3] = 19'h7FFFE;
    pool_asid[0] = 8'h01; pool_asid[1] = 8'h02; pool_asid[2] = 8'hF0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        set_w($urandom_range(0, 15), pool_vpn2[$urandom_range(0, 3)],
              pool_asid[$urandom_range(0, 2)], bit'($urandom_range(0, 3) == 0),
              20'($urandom), 3'($urandom), bit'($urandom), bit'($urandom),
              20'($urandom), 3'($urandom), bit'($urandom), bit'($urandom));
      end else begin
        we = 1'b0;
      end
      drive_s0(pool_vpn2[$urandom_range(0, 3)], bit'($urandom), pool_asid[$urandom_range(0, 2)]);
      drive_s1(pool_vpn2[$urandom_range(0, 3)], bit'($urandom), pool_asid[$urandom_range(0, 2)]);
      r_index = 4'($urandom);
      check_model("rnd");
      @(posedge clk);
      if (we) commit_model();
      #1;
    end
    we = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlb.md
# tlb

Fully associative 16-entry MIPS32 joint TLB sitting beside the CP0 register file. It holds the page-table entries written by TLBWI, returns entry contents for TLBR, and provides two concurrent lookup ports. Port 0 serves instruction fetch; port 1 serves data access and TLBP. It supplies the CP0 `tlbp_found`/`index` and `r_*` inputs, and consumes CP0 EntryHi/EntryLo0/EntryLo1/Index contents on writes.

## Interface
- TLBNUM, 16, number of entries; index width is log2(TLBNUM) = 4 and matches the CP0 Index field.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all entry valid state.
- s0_vpn2 / s0_odd_page / s0_asid  in  19/1/8  fetch lookup key: VA[31:13], VA[12], ASID.
- s0_found  out  1  fetch hit.
- s0_index  out  4  hit entry number.
- s0_pfn / s0_c / s0_d / s0_v  out  20/3/1/1  selected page-half fields.
- s1_vpn2 / s1_odd_page / s1_asid  in  19/1/8  data/TLBP lookup key.
- s1_found / s1_index / s1_pfn / s1_c / s1_d / s1_v  out  1/4/20/3/1/1  same meaning as port 0.
- we  in  1  TLBWI write strobe.
- w_index  in  4  entry to write.
- w_vpn2 / w_asid / w_g  in  19/8/1  EntryHi fields; G = EntryLo0.G & EntryLo1.G.
- w_pfn0 / w_c0 / w_d0 / w_v0  in  20/3/1/1  even-page fields.
- w_pfn1 / w_c1 / w_d1 / w_v1  in  20/3/1/1  odd-page fields.
- r_index  in  4  TLBR entry select.
- r_vpn2 / r_asid / r_g / r_pfn0 / r_c0 / r_d0 / r_v0 / r_pfn1 / r_c1 / r_d1 / r_v1  out  widths as w_*  entry contents.

## Operation
- Storage: per entry vpn2[18:0], asid[7:0], g, pfn0/c0/d0/v0, pfn1/c1/d1/v1, plus an internal `present` bit.
- Write: when `we` is asserted at a clk edge, all fields of entry `w_index` load from the w_* inputs and `present` is set. No other entry changes.
- Match condition for entry i: present[i], vpn2[i] == s_vpn2, and (g[i] or asid[i] == s_asid).
- found = OR of all matches.
- Multiple matches are software error. The lowest-numbered matching entry supplies index and fields.
- Page select: odd_page = 0 selects pfn0/c0/d0/v0; odd_page = 1 selects pfn1/c1/d1/v1.
- On a miss, s*_index, s*_pfn, s*_c, s*_d and s*_v are all 0.
- The `v` and `d` outputs are reported only. The TLB never raises exceptions; the MMU stage generates TLBL/TLBS/Mod from found/v/d.
- Read: r_* outputs give entry `r_index` combinationally. Reading an entry never written returns all zeros.
- TLBP: the CPU drives s1 with EntryHi vpn2/asid. s1_found maps to CP0 `tlbp_found`; s1_index maps to CP0 `index`.

## Timing
- Lookup and read paths are combinational, with zero latency from key/index to outputs.
- A write is visible from the cycle after the `we` edge.
- Same-cycle write and lookup/read of the same entry returns the old contents.
- Two writes on consecutive cycles are both honoured; there is no busy period.
- Reset asserted asynchronously at any time: all present bits clear immediately. s0_found and s1_found go 0 within the same cycle, and all r_* outputs read 0.
- Reset has no effect on other fields beyond masking through `present`, and must not glitch clk-domain logic on release.
- A `we` coinciding with reset is ignored.

## Structure
- Add TLBNUM, TLB index width and field width macros to the shared header `mycpu.h`, next to the CR_* and EX_* constants.
- One sub-module, `tlb_match`, is natural. It takes one lookup key and the flattened entry arrays and returns found/index/fields. It is instantiated twice, for s0 and s1.
- Entry arrays are flat regs indexed by entry number. No RAM macro is used, because lookup must be combinational over all entries.

## Test plan
- Reset, then lookup vpn2 = 0, asid = 0 on both ports -> s0_found = s1_found = 0; r_index = 5 gives all r_* = 0.
- Write entry 3: vpn2 = 19'h00400, asid = 8'h12, g = 0, pfn0 = 20'h01000, v0 = 1, pfn1 = 20'h01001, d1 = 1, v1 = 1.
  - Lookup (19'h00400, odd = 1, asid 8'h12) -> found = 1, index = 3, pfn = 20'h01001, d = 1.
  - Same key with asid 8'h13 -> found = 0.
- Write entry 7 with g = 1, vpn2 = 19'h7FFFF. Lookup with any asid (8'h00, 8'hFF) -> found = 1, index = 7, on both ports simultaneously with different page halves.
- Write entries 2 and 9 with an identical key. Lookup -> index = 2. Then overwrite entry 2 with vpn2 = 19'h1 -> the next cycle's lookup returns index = 9.
- Assert we on entry 4 and a lookup of entry 4's new key in the same cycle -> found = 0 that cycle, found = 1 the next cycle. Pulse reset mid-cycle afterwards -> found drops to 0 before the next edge.
